// File: rtl/mem_word_ctrl_pkg.sv
// Shared definitions for the word-to-byte-lane memory controller: default
// parameter values and the FSM state encoding, used by the RTL and its bench.
package mem_word_ctrl_pkg;

  localparam int DEF_BUS_SIZE      = 32;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_NUM_MEM_UNITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_LAST = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_word_ctrl_if.sv
// Word request/response handshake plus the byte-wide memory unit port.
// slave is the controller's view; master is the requester + memory unit side.
interface mem_word_ctrl_if
  import mem_word_ctrl_pkg::*;
#(
  parameter int BUS_SIZE        = DEF_BUS_SIZE,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int MEM_UNIT_WIDTH  = DEF_BUS_SIZE / DEF_NUM_MEM_UNITS,
  parameter int WORD_ADDR_WIDTH = DEF_ADDR_WIDTH - $clog2(DEF_NUM_MEM_UNITS)
);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [WORD_ADDR_WIDTH-1:0] req_addr;
  logic [BUS_SIZE-1:0]        req_wdata;
  logic                       rsp_valid;
  logic [BUS_SIZE-1:0]        rsp_rdata;
  logic                       mem_read;
  logic                       mem_write;
  logic [ADDR_WIDTH-1:0]      mem_address;
  logic [MEM_UNIT_WIDTH-1:0]  mem_data_in;
  logic [MEM_UNIT_WIDTH-1:0]  mem_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_read, mem_write, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_read, mem_write, mem_address, mem_data_in
  );

endinterface

// File: rtl/mem_word_ctrl.sv
// Splits each word request into NUM_MEM_UNITS byte-lane accesses to a
// byte-wide memory unit (lane 0 first) and reassembles read words.
module mem_word_ctrl
  import mem_word_ctrl_pkg::*;
#(
  parameter int BUS_SIZE        = DEF_BUS_SIZE,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int NUM_MEM_UNITS   = DEF_NUM_MEM_UNITS,
  parameter int MEM_UNIT_WIDTH  = BUS_SIZE / NUM_MEM_UNITS,
  parameter int WORD_ADDR_WIDTH = ADDR_WIDTH - $clog2(NUM_MEM_UNITS)
) (
  input  logic            clk,
  input  logic            reset_L,
  mem_word_ctrl_if.slave  bus
);

  localparam int                LANE_W    = $clog2(NUM_MEM_UNITS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_MEM_UNITS - 1);

  state_t                     r_state;
  logic [LANE_W-1:0]          r_lane;
  logic [WORD_ADDR_WIDTH-1:0] r_addr;
  logic [BUS_SIZE-1:0]        r_wdata;
  logic [BUS_SIZE-1:0]        r_rd_buf;
  logic [BUS_SIZE-1:0]        r_rsp_rdata;
  logic                       r_rsp_valid;
  logic                       r_mem_read;
  logic                       r_mem_write;
  logic [ADDR_WIDTH-1:0]      r_mem_address;
  logic [MEM_UNIT_WIDTH-1:0]  r_mem_data_in;

  logic                       w_accept;
  logic [LANE_W-1:0]          w_next_lane;
  logic [LANE_W-1:0]          w_prev_lane;
  logic [BUS_SIZE-1:0]        w_rd_word;

  assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
  assign w_next_lane = r_lane + 1'b1;
  assign w_prev_lane = r_lane - 1'b1;

  // The last lane arrives straight from the memory unit in RD_LAST.
  always_comb begin
    w_rd_word = r_rd_buf;
    w_rd_word[BUS_SIZE-1 -: MEM_UNIT_WIDTH] = bus.mem_data_out;
  end

  // NOTE: every register below uses <= so all state advances together on the
  // edge; a blocking = here would let later statements see mid-update values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state       <= ST_IDLE;
      r_lane        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rd_buf      <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr        <= bus.req_addr;
            r_wdata       <= bus.req_wdata;
            r_lane        <= '0;
            r_mem_address <= {bus.req_addr, LANE_W'(0)};
            if (bus.req_write) begin
              r_mem_write   <= 1'b1;
              r_mem_data_in <= bus.req_wdata[MEM_UNIT_WIDTH-1:0];
              r_state       <= ST_WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= ST_RD;
            end
          end
        end
        ST_WR: begin
          if (r_lane == LAST_LANE) begin
            r_mem_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_lane        <= w_next_lane;
            r_mem_address <= {r_addr, w_next_lane};
            r_mem_data_in <= r_wdata[w_next_lane*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH];
          end
        end
        ST_RD: begin
          // Read data lags the strobe by one cycle, so this edge captures the
          // lane addressed in the previous cycle.
          if (r_lane != '0)
            r_rd_buf[w_prev_lane*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH] <= bus.mem_data_out;
          if (r_lane == LAST_LANE) begin
            r_mem_read <= 1'b0;
            r_state    <= ST_RD_LAST;
          end else begin
            r_lane        <= w_next_lane;
            r_mem_address <= {r_addr, w_next_lane};
          end
        end
        ST_RD_LAST: begin
          r_rsp_rdata <= w_rd_word;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_lane      <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: req_ready is the one combinational output; it must follow the state
  // in the same cycle so a request can be accepted on the first IDLE edge.
  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;

endmodule
